// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// In-order FIFO write buffer between the store ECC encoder and the data cache
// write port. Entries of {address, 32-bit data, 16-bit check word} are pushed
// from the encoder side and drained first-word-fall-through to the cache over
// a valid/ready handshake. The head check word is self-checked on the way out
// (out_chk_err). err_cnt counts the drained entries whose check word is bad.
//
// Optional build macro: STORE_FWD_EN
//   When defined, a combinational store-to-load forwarding lookup compares
//   ld_addr against every live entry. The youngest match drives ld_data.
//   When undefined, ld_hit/ld_data are tied to 0 and no comparators exist.
//
// Parameters
//   DEPTH : number of entries, power of two, 2..16
//   AW    : store address width
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             encoder-side handshake
//   in_addr/in_data/in_parity     entry being offered
//   flush                         synchronous discard of all entries
//   out_valid/out_ready           cache-side handshake
//   out_addr/out_data/out_parity  head entry (valid only while out_valid=1)
//   out_chk_err                   head check word fails its self-check
//   count                         current occupancy (0..DEPTH)
//   err_cnt                       saturating count of bad entries drained
//   ld_addr/ld_hit/ld_data        store-to-load forwarding lookup
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [31:0]              in_data,
    input  logic [15:0]              in_parity,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AW-1:0]            out_addr,
    output logic [31:0]              out_data,
    output logic [15:0]              out_parity,
    output logic                     out_chk_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               err_cnt,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [31:0]              ld_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage: never reset; contents are only meaningful for live slots.
    logic [AW-1:0] addr_mem   [DEPTH];
    logic [31:0]   data_mem   [DEPTH];
    logic [15:0]   parity_mem [DEPTH];

    logic [PW-1:0] head_reg,    head_next;
    logic [PW-1:0] tail_reg,    tail_next;
    logic [CW-1:0] count_reg,   count_next;
    logic [7:0]    err_cnt_reg, err_cnt_next;

    logic push;
    logic pop;

    // Handshake flags depend on registered occupancy only, so a full buffer
    // refuses a push even when the cache pops in the same cycle.
    assign in_ready  = (count_reg != CW'(DEPTH));
    assign out_valid = (count_reg != '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // First-word fall-through head view.
    assign out_addr    = addr_mem[head_reg];
    assign out_data    = data_mem[head_reg];
    assign out_parity  = parity_mem[head_reg];
    // Bit 15 is the even-parity bit over bits 14:7.
    assign out_chk_err = ^out_parity[15:7];

    assign count   = count_reg;
    assign err_cnt = err_cnt_reg;

    always_comb begin
        head_next    = head_reg;
        tail_next    = tail_reg;
        count_next   = count_reg;
        err_cnt_next = err_cnt_reg;
        if (flush) begin
            // Flush wins over any push/pop this cycle; err_cnt is kept.
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) begin
                tail_next = tail_reg + PW'(1);
            end
            if (pop) begin
                head_next = head_reg + PW'(1);
                if (out_chk_err && (err_cnt_reg != 8'hFF)) begin
                    err_cnt_next = err_cnt_reg + 8'd1;
                end
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            err_cnt_reg <= '0;
        end else begin
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            count_reg   <= count_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            addr_mem[tail_reg]   <= in_addr;
            data_mem[tail_reg]   <= in_data;
            parity_mem[tail_reg] <= in_parity;
        end
    end

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0] slot_match;

    // A slot is live when its distance from the head is below the occupancy.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fwd_cmp
            logic [PW-1:0] slot_age;
            logic          slot_live;
            assign slot_age        = PW'(gi) - head_reg;
            assign slot_live       = ({1'b0, slot_age} < count_reg);
            assign slot_match[gi]  = slot_live && (addr_mem[gi] == ld_addr);
        end
    endgenerate

    // Walk from oldest to youngest so the last match seen (closest to the
    // tail) supplies the forwarded data.
    always_comb begin
        logic [PW-1:0] idx;
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_reg + PW'(k);
            if (slot_match[idx]) begin
                ld_hit  = 1'b1;
                ld_data = data_mem[idx];
            end
        end
    end
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^ld_addr;
    assign ld_hit         = 1'b0;
    assign ld_data        = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [15:0] in_parity;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [15:0] out_parity;
    logic        out_chk_err;
    logic [2:0]  count;
    logic [7:0]  err_cnt;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .in_parity   (in_parity),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_parity  (out_parity),
        .out_chk_err (out_chk_err),
        .count       (count),
        .err_cnt     (err_cnt),
        .ld_addr     (ld_addr),
        .ld_hit      (ld_hit),
        .ld_data     (ld_data)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of entries plus an error tally.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [15:0] p;
    } ent_t;

    ent_t q[$];
    int   err_m;
    int   total;
    int   bad;

    function automatic bit parity_bad(logic [15:0] p);
        // Bit 15 should equal the XOR of bits 14..7.
        return (p[15] != (^p[14:7]));
    endfunction

    task automatic cmp(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit          hit_m;
        logic [31:0] fwd_m;
        cmp("count", 64'(count), 64'(q.size()));
        cmp("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        cmp("out_valid", 64'(out_valid), 64'(q.size() != 0));
        cmp("err_cnt", 64'(err_cnt), 64'(err_m));
        if (q.size() != 0) begin
            cmp("out_addr", 64'(out_addr), 64'(q[0].a));
            cmp("out_data", 64'(out_data), 64'(q[0].d));
            cmp("out_parity", 64'(out_parity), 64'(q[0].p));
            cmp("out_chk_err", 64'(out_chk_err), 64'(parity_bad(q[0].p)));
        end
        hit_m = 1'b0;
        fwd_m = '0;
`ifdef STORE_FWD_EN
        foreach (q[i]) begin
            if (q[i].a == ld_addr) begin
                hit_m = 1'b1;
                fwd_m = q[i].d;
            end
        end
`endif
        cmp("ld_hit", 64'(ld_hit), 64'(hit_m));
        if (hit_m) cmp("ld_data", 64'(ld_data), 64'(fwd_m));
    endtask

    // Apply the currently driven inputs across one rising edge, update the
    // model from the queue's own occupancy, then check everything.
    task automatic cycle();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = in_valid && (q.size() != DEPTH) && !flush;
        do_pop  = out_ready && (q.size() != 0) && !flush;
        e.a = in_addr;
        e.d = in_data;
        e.p = in_parity;
        @(posedge clk);
        #1;
        if (flush) begin
            $display("flush: dropped %0d entries", q.size());
            q.delete();
        end else begin
            if (do_pop) begin
                $display("pop  a=%08h d=%08h p=%04h", q[0].a, q[0].d, q[0].p);
                if (parity_bad(q[0].p) && err_m < 255) err_m++;
                void'(q.pop_front());
            end
            if (do_push) begin
                $display("push a=%08h d=%08h p=%04h", e.a, e.d, e.p);
                q.push_back(e);
            end
        end
        check_all();
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic offer(logic [31:0] a, logic [31:0] d, logic [15:0] p);
        in_valid  = 1'b1;
        in_addr   = a;
        in_data   = d;
        in_parity = p;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        err_m     = 0;
        rst_n     = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        in_parity = '0;
        ld_addr   = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();

        // First push becomes visible one cycle later.
        offer(32'h10, 32'hDEADBEEF, 16'h0000);
        cycle();
        idle();
        cmp("first_data", 64'(out_data), 64'hDEADBEEF);
        out_ready = 1'b1;
        cycle();
        idle();

        // Fill to DEPTH, then offer one more while the cache pops.
        for (int i = 0; i < DEPTH; i++) begin
            offer(32'h100 + 32'(4 * i), 32'(i + 16), 16'h0000);
            cycle();
        end
        cmp("full_ready", 64'(in_ready), 64'd0);
        offer(32'h200, 32'h55, 16'h0000);
        out_ready = 1'b1;
        cycle();
        cmp("full_refuse", 64'(count), 64'd3);
        in_valid = 1'b0;
        repeat (3) cycle();
        idle();

        // In-order drain with stalling cache.
        for (int i = 1; i <= 3; i++) begin
            offer(32'h300 + 32'(i), 32'(i), 16'h0000);
            cycle();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            cycle();
        end
        idle();
        cmp("drain_empty", 64'(count), 64'd0);

        // Flush at count=2 with a push offered.
        offer(32'h400, 32'hA1, 16'h8000);
        cycle();
        offer(32'h404, 32'hA2, 16'h8000);
        cycle();
        flush = 1'b1;
        offer(32'h408, 32'hA3, 16'h0000);
        cycle();
        idle();
        cmp("flush_count", 64'(count), 64'd0);

`ifdef STORE_FWD_EN
        offer(32'h40, 32'hA, 16'h0000);
        cycle();
        offer(32'h40, 32'hB, 16'h0000);
        ld_addr = 32'h40;
        cycle();
        idle();
        cmp("fwd_hit", 64'(ld_hit), 64'd1);
        cmp("fwd_data", 64'(ld_data), 64'hB);
        ld_addr = 32'h44;
        #1;
        check_all();
        cmp("fwd_miss", 64'(ld_hit), 64'd0);
        flush = 1'b1;
        cycle();
        idle();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(2) != 0);
            in_addr   = 32'h40 + 32'(4 * $urandom_range(3));
            in_data   = $urandom;
            in_parity = 16'($urandom);
            out_ready = ($urandom_range(1) != 0);
            flush     = ($urandom_range(24) == 0);
            ld_addr   = 32'h40 + 32'(4 * $urandom_range(3));
            cycle();
        end
        idle();
        flush = 1'b1;
        cycle();
        idle();

        // Corrupt check words until the counter saturates.
        for (int i = 0; i < 300; i++) begin
            offer(32'h500, 32'(i), 16'h8000);
            out_ready = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        idle();
        cmp("err_sat", 64'(err_cnt), 64'd255);

        // Asynchronous reset between clock edges.
        offer(32'h600, 32'h77, 16'h0000);
        cycle();
        cycle();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        q.delete();
        err_m = 0;
        cmp("async_count", 64'(count), 64'd0);
        cmp("async_err", 64'(err_cnt), 64'd0);
        cmp("async_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO write buffer between the store ECC encoder and the data cache write port.
- Captures {address, 32-bit data, 16-bit parity} entries from the encoder side and drains them in order to the cache through a valid/ready handshake.
- Checks the stored parity word on drain and reports corruption.
- Optionally gives store-to-load forwarding to the load path.

Parameters:
- DEPTH, 4, number of entries; power of two, range 2..16
- AW, 32, store address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  store entry offered by the encoder side
- in_ready  out  1  buffer can accept an entry
- in_addr  in  AW  store address
- in_data  in  32  data word (the encoder's data_Cache)
- in_parity  in  16  check word (the encoder's parity_Cache)
- flush  in  1  synchronous discard of all entries
- out_valid  out  1  head entry available to the cache
- out_ready  in  1  cache accepts the head entry
- out_addr  out  AW  head address
- out_data  out  32  head data
- out_parity  out  16  head check word
- out_chk_err  out  1  head check word fails its self-check
- count  out  $clog2(DEPTH)+1  current occupancy
- err_cnt  out  8  saturating count of drained entries with out_chk_err=1
- ld_addr  in  AW  load lookup address (used only with STORE_FWD_EN)
- ld_hit  out  1  forwarding hit (used only with STORE_FWD_EN)
- ld_data  out  32  forwarded data (used only with STORE_FWD_EN)

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset: pointers=0, count=0, err_cnt=0, out_valid=0, in_ready=1, ld_hit=0.
  - Entry storage is not reset.
  - out_addr, out_data, out_parity, out_chk_err, ld_data are don't-care while out_valid=0 or ld_hit=0.
- Push: occurs when in_valid && in_ready. The entry is written at the tail and the tail increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready. The head increments modulo DEPTH.
- in_ready = (count != DEPTH). Depends on registered state only, never on out_ready.
  - When full, a push is refused even if a pop happens in the same cycle.
- out_valid = (count != 0). Head fields are read combinationally from the head entry (first-word fall-through).
  - Latency from push to out_valid is 1 cycle when empty.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Simultaneous push and pop with count=1: the new entry becomes head the next cycle; out_valid stays 1.
- Handshake stability: while out_valid=1 && out_ready=0, all out_* fields hold stable.
- The input side does not require in_valid to be held. An offered entry not accepted is simply not taken.
- out_chk_err = XOR of out_parity[15:7]. It is 1 when parity[15] disagrees with the XOR of parity[14:7].
  - Entries are passed through unmodified; the buffer never corrects.
- err_cnt increments by 1 on each pop with out_chk_err=1 and saturates at 255.
  - It is cleared only by reset; flush does not clear it.
- flush: next cycle pointers=0, count=0, out_valid=0.
  - Flush overrides any push or pop in the same cycle; the push is dropped and no err_cnt update occurs.
  - in_ready remains governed by count, so it is 1 after a flush.
- Reset mid-operation clears all state immediately, independent of clk.
- Pointer width is $clog2(DEPTH). count is one bit wider so it can represent DEPTH.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined: ld_hit=1 when any valid entry's address equals ld_addr.
  - ld_data carries the youngest matching entry's data (closest to tail).
  - The lookup is combinational against registered contents. An entry pushed in the same cycle is not visible until the next cycle.
  - An entry popped in the same cycle is still visible.
- Not defined: ld_hit is tied to 0 and ld_data to 0. No comparator logic is generated and the ports remain present.

Test Plan:
- Reset, then push addr=0x10, data=0xDEADBEEF, parity=0x0000 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_chk_err=0, count=1.
- DEPTH=4: push 4 entries with out_ready=0 -> in_ready=0, count=4. Offer a 5th with out_ready=1 -> 5th not taken, count=3 next cycle.
- Push data values 1,2,3 and drain with out_ready toggling 1,0,1,0… -> popped in order 1,2,3, fields stable during stalls, count returns to 0.
- Push parity=0x8000 (bit 15 set, [14:7]=0) and pop -> out_chk_err=1, err_cnt=1. Repeat 300 times -> err_cnt=255.
- With count=2, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, err_cnt unchanged.
- STORE_FWD_EN defined: push (0x40, 0xA), then (0x40, 0xB), and set ld_addr=0x40 -> ld_hit=1, ld_data=0xB. ld_addr=0x44 -> ld_hit=0. Undefined -> ld_hit=0 always.
